spi_master_cfg: RTL

Parametrised SPI master: successor to the fixed 8-bit, mode-0 joystick link. Supports programmable word width, all four SPI modes (CPOL/CPHA), a runtime clock divider and multi-word frames under a single chip-select. Sits between the game-control logic and any SPI peripheral (PmodJSTK, future pads/sensors), fully synchronous to the system clock with no use of `clk` as SPI clock.

---
 rtl/spi_master_cfg.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_cfg.sv
// spi_master_cfg
// Configurable SPI master: programmable word width, all four CPOL/CPHA modes,
// runtime SCLK divider and multi-word frames under a single chip-select.
// All logic runs on the rising edge of clk; SCLK is a registered output
// produced by a half-period down-counter, never derived from clk itself.
//
// Build option:
//   SPI_MASTER_LOOPBACK_EN  adds input 'loopback'; when high the receive path
//                           samples the internal mosi register instead of miso.
//
// Frame timeline (H = clk_div+1, W = frame_len+1):
//   SETUP  H cycles, cs_n low, sclk idle
//   SHIFT  2*DATA_W*W half-periods; every half-period ends in an SCLK edge,
//          so the last edge of a word is the one closing its final half-period
//   HOLD   H cycles, sclk back at idle level, mosi low
//   DONE   1 cycle, cs_n high, done pulse
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              mosi,
  output logic              sclk,
  output logic              cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              din_ack,
  output logic              busy,
  output logic              done
);

  // Half-period index within one word: 0 .. 2*DATA_W-1.
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] HALF_LAST      = HW'(2 * DATA_W - 1);
  localparam logic [HW-1:0] HALF_LAST_LEAD = HW'(2 * DATA_W - 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic                cpol_r;
  logic                cpha_r;
  logic [DIV_W-1:0]    div_r;
  logic [LEN_W-1:0]    len_r;
  logic [DIV_W-1:0]    cnt_r;
  logic [HW-1:0]       half_r;
  logic [LEN_W-1:0]    word_r;
  logic [DATA_W-1:0]   tx_sr_r;
  logic [DATA_W-1:0]   rx_sr_r;
  logic                mosi_r;
  logic                sclk_r;
  logic                cs_n_r;
  logic [DATA_W-1:0]   data_out_r;
  logic                data_out_valid_r;
  logic                din_ack_r;
  logic                busy_r;
  logic                done_r;

  logic                tick_s;
  logic                sample_s;
  logic                last_sample_s;
  logic                word_end_s;
  logic                last_word_s;
  logic                rx_bit_s;
  logic [DATA_W-1:0]   rx_next_s;

  // Half-period counter expiry; every expiry in SHIFT is an SCLK edge.
  assign tick_s = (cnt_r == {DIV_W{1'b0}});

  // Even half_r values are leading edges (sclk moves away from idle level).
  // cpha=0 samples on leading edges, cpha=1 on trailing edges.
  assign sample_s      = cpha_r ? half_r[0] : ~half_r[0];
  assign last_sample_s = cpha_r ? (half_r == HALF_LAST) : (half_r == HALF_LAST_LEAD);
  assign word_end_s    = (half_r == HALF_LAST);

  // frame_len is words-minus-one, so the last word index equals frame_len;
  // an all-ones frame_len therefore yields 2^LEN_W words without overflow.
  assign last_word_s = (word_r == len_r);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit_s = loopback ? mosi_r : miso;
`else
  assign rx_bit_s = miso;
`endif

  assign rx_next_s = {rx_sr_r[DATA_W-2:0], rx_bit_s};

  // Frame sequencer: state, SCLK generation, shift registers and all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= ST_IDLE;
      cpol_r           <= 1'b0;
      cpha_r           <= 1'b0;
      div_r            <= {DIV_W{1'b0}};
      len_r            <= {LEN_W{1'b0}};
      cnt_r            <= {DIV_W{1'b0}};
      half_r           <= {HW{1'b0}};
      word_r           <= {LEN_W{1'b0}};
      tx_sr_r          <= {DATA_W{1'b0}};
      rx_sr_r          <= {DATA_W{1'b0}};
      mosi_r           <= 1'b0;
      sclk_r           <= 1'b0;
      cs_n_r           <= 1'b1;
      data_out_r       <= {DATA_W{1'b0}};
      data_out_valid_r <= 1'b0;
      din_ack_r        <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      data_out_valid_r <= 1'b0;
      din_ack_r        <= 1'b0;
      done_r           <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Idle SCLK level follows cpol live until a frame starts.
          cpol_r <= cpol;
          sclk_r <= cpol;
          mosi_r <= 1'b0;
          if (start) begin
            cpha_r    <= cpha;
            div_r     <= clk_div;
            len_r     <= frame_len;
            cnt_r     <= clk_div;
            tx_sr_r   <= data_in;
            // cpha=0 must present the MSB before the first leading edge.
            mosi_r    <= cpha ? 1'b0 : data_in[DATA_W-1];
            din_ack_r <= 1'b1;
            cs_n_r    <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= ST_SETUP;
          end else begin
            cs_n_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end

        ST_SETUP: begin
          if (tick_s) begin
            cnt_r   <= div_r;
            half_r  <= {HW{1'b0}};
            word_r  <= {LEN_W{1'b0}};
            state_r <= ST_SHIFT;
          end else begin
            cnt_r <= cnt_r - DIV_W'(1);
          end
        end

        ST_SHIFT: begin
          if (tick_s) begin
            cnt_r  <= div_r;
            sclk_r <= ~sclk_r;
            if (sample_s) begin
              rx_sr_r <= rx_next_s;
              if (last_sample_s) begin
                data_out_r       <= rx_next_s;
                data_out_valid_r <= 1'b1;
              end
            end
            if (word_end_s) begin
              // Edge closing the word's last half-period.
              half_r <= {HW{1'b0}};
              if (last_word_s) begin
                sclk_r  <= cpol_r;
                mosi_r  <= 1'b0;
                state_r <= ST_HOLD;
              end else begin
                // Next word follows with no gap; for cpha=0 this trailing
                // edge is also where its MSB has to appear.
                word_r    <= word_r + LEN_W'(1);
                tx_sr_r   <= data_in;
                din_ack_r <= 1'b1;
                if (!cpha_r) begin
                  mosi_r <= data_in[DATA_W-1];
                end
              end
            end else begin
              half_r <= half_r + HW'(1);
              if (!sample_s) begin
                // Shift edge: cpha=0 moves to the next bit, cpha=1 puts out
                // the current one ahead of its trailing-edge sample.
                mosi_r  <= cpha_r ? tx_sr_r[DATA_W-1] : tx_sr_r[DATA_W-2];
                tx_sr_r <= {tx_sr_r[DATA_W-2:0], 1'b0};
              end
            end
          end else begin
            cnt_r <= cnt_r - DIV_W'(1);
          end
        end

        ST_HOLD: begin
          if (tick_s) begin
            cs_n_r  <= 1'b1;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - DIV_W'(1);
          end
        end

        ST_DONE: begin
          sclk_r  <= cpol_r;
          mosi_r  <= 1'b0;
          cs_n_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          sclk_r  <= cpol_r;
          mosi_r  <= 1'b0;
          cs_n_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign mosi           = mosi_r;
  assign sclk           = sclk_r;
  assign cs_n           = cs_n_r;
  assign data_out       = data_out_r;
  assign data_out_valid = data_out_valid_r;
  assign din_ack        = din_ack_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule
